// File: rtl/core_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_meas_pkg
// Description : Shared types and default widths for the analog-core response
//               measurement block. The default code widths match the ones
//               used by the core stimulus driver.
// Contents    : meas_state_t  - measurement FSM state (2-bit encoding)
//               c_def_cw      - default edge counter / result width
//               c_def_ww      - default window-length width
//               c_def_sync    - default synchronizer depth
// Revision    : 1.0 - initial release
// ============================================================================
package core_meas_pkg;

  localparam int c_def_cw   = 8;
  localparam int c_def_ww   = 16;
  localparam int c_def_sync = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } meas_state_t;

endpackage
`default_nettype wire

// File: rtl/core_meas_sync.sv
`default_nettype none
// ============================================================================
// Module      : core_meas_sync
// Description : SYNC-deep synchronizer for an asynchronous core output plus a
//               rising-edge detector on the synchronized level. Usable for any
//               asynchronous digital output of the analog core.
// Ports       : clk   - system clock
//               reset - asynchronous active-high reset (clears all flops)
//               din   - asynchronous input level
//               rise  - one-cycle pulse per rising edge of the synced level
// Revision    : 1.0 - initial release
// ============================================================================
module core_meas_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  // r_chain[SYNC-1] is the synchronized level; r_prev is that level one
  // cycle later, giving the edge history.
  logic [SYNC-1:0] r_chain;
  logic            r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain <= {r_chain[SYNC-2:0], din};
      r_prev  <= r_chain[SYNC-1];
    end
  end

  assign rise = r_chain[SYNC-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/core_meas.sv
`default_nettype none
// ============================================================================
// Module      : core_meas
// Description : Counts rising edges of an asynchronous analog-core output over
//               a programmable window of clk cycles, then presents the result
//               through a valid/ack handshake.
// Ports       : clk     - system clock (10 MHz nominal)
//               reset   - asynchronous active-high reset
//               cmp_i   - asynchronous comparator/oscillator output
//               start   - single-cycle pulse, begins a measurement in IDLE
//               abort   - single-cycle pulse, cancels a running measurement
//               win_len - window length in clk cycles (0 treated as 1)
//               ack     - consumer acknowledges the presented result
//               busy    - measurement in progress (ARM or COUNT)
//               valid   - result available (DONE)
//               count   - edges counted in the last completed window
//               ovf     - counter saturated during the last completed window
// Revision    : 1.0 - initial release
// ============================================================================
module core_meas
  import core_meas_pkg::*;
#(
  parameter int CW   = c_def_cw,
  parameter int WW   = c_def_ww,
  parameter int SYNC = c_def_sync
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmp_i,
  input  logic          start,
  input  logic          abort,
  input  logic [WW-1:0] win_len,
  input  logic          ack,
  output logic          busy,
  output logic          valid,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam int                c_armw     = 3;
  localparam logic [c_armw-1:0] c_arm_one  = c_armw'(1);
  localparam logic [c_armw-1:0] c_arm_last = c_armw'(SYNC - 1);
  localparam logic [WW-1:0]     c_win_one  = WW'(1);
  localparam logic [CW-1:0]     c_acc_one  = CW'(1);

  meas_state_t       r_state;
  meas_state_t       w_state_next;
  logic              r_rst_meta;
  logic              r_rst_sync;
  logic              w_rst;
  logic              w_rise;
  logic              w_start_ok;
  logic              w_sat;
  logic [CW-1:0]     w_acc_inc;
  logic              w_ovf_inc;
  logic              w_busy_d;
  logic              w_valid_d;
  logic [c_armw-1:0] r_arm_cnt;
  logic [WW-1:0]     r_win;
  logic [CW-1:0]     r_acc;
  logic              r_ovf_int;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic              r_busy;
  logic              r_valid;

  // Reset asserts asynchronously and releases two clk edges after the
  // external reset drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= 1'b1;
    end else begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst = r_rst_sync;

  core_meas_sync #(
    .SYNC (SYNC)
  ) u_sync (
    .clk   (clk),
    .reset (w_rst),
    .din   (cmp_i),
    .rise  (w_rise)
  );

  // abort outranks start in IDLE.
  assign w_start_ok = start & ~abort;

  // Saturating accumulate: an edge that arrives while the accumulator is
  // already all-ones is lost, and that loss is what ovf reports.
  assign w_sat     = &r_acc;
  assign w_acc_inc = (w_rise && !w_sat) ? r_acc + c_acc_one : r_acc;
  assign w_ovf_inc = r_ovf_int | (w_rise & w_sat);

  // State register
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_next = ARM;
      ARM: begin
        if (abort)                        w_state_next = IDLE;
        else if (r_arm_cnt == c_arm_last) w_state_next = COUNT;
      end
      COUNT: begin
        if (abort)                   w_state_next = IDLE;
        else if (r_win == c_win_one) w_state_next = DONE;
      end
      DONE:    if (abort || ack) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode from the next state so busy/valid come straight off flops.
  always_comb begin
    w_busy_d  = 1'b0;
    w_valid_d = 1'b0;
    case (w_state_next)
      ARM, COUNT: w_busy_d  = 1'b1;
      DONE:       w_valid_d = 1'b1;
      default:    ;
    endcase
  end

  // Counters, result registers and registered outputs
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_arm_cnt <= '0;
      r_win     <= '0;
      r_acc     <= '0;
      r_ovf_int <= 1'b0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_busy  <= w_busy_d;
      r_valid <= w_valid_d;

      // ARM length counter; edges seen during ARM are simply not accumulated.
      r_arm_cnt <= (r_state == ARM && w_state_next == ARM) ? r_arm_cnt + c_arm_one : '0;

      case (r_state)
        IDLE: begin
          r_acc     <= '0;
          r_ovf_int <= 1'b0;
          // Window is held untouched through ARM, so it is loaded here.
          if (w_start_ok) r_win <= (win_len == '0) ? c_win_one : win_len;
        end
        COUNT: begin
          r_win     <= r_win - c_win_one;
          r_acc     <= w_acc_inc;
          r_ovf_int <= w_ovf_inc;
          // The last window cycle's edge is folded into the result.
          if (w_state_next == DONE) begin
            r_count <= w_acc_inc;
            r_ovf   <= w_ovf_inc;
          end
        end
        default: ;
      endcase

      if (abort) begin
        r_acc     <= '0;
        r_ovf_int <= 1'b0;
      end
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign count = r_count;
  assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_core_meas.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_meas
// Description : Self-checking bench for core_meas. Two instances (CW=8 and
//               CW=4) share all stimulus. The expected count is derived from
//               the bench's own record of cmp_i as sampled at each clk edge:
//               rising transitions among the samples taken at the start edge
//               and the following wlen edges, saturated to 2^CW-1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_meas;

  localparam int SYNC = 2;
  localparam int WW   = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmp_i;
  logic          start;
  logic          abort;
  logic          ack;
  logic [WW-1:0] win_len;
  logic          busy8, valid8, ovf8;
  logic [7:0]    count8;
  logic          busy4, valid4, ovf4;
  logic [3:0]    count4;

  always #50 clk = ~clk;

  core_meas #(.CW(8), .WW(WW), .SYNC(SYNC)) dut8 (
    .clk(clk), .reset(reset), .cmp_i(cmp_i), .start(start), .abort(abort),
    .win_len(win_len), .ack(ack), .busy(busy8), .valid(valid8),
    .count(count8), .ovf(ovf8)
  );

  core_meas #(.CW(4), .WW(WW), .SYNC(SYNC)) dut4 (
    .clk(clk), .reset(reset), .cmp_i(cmp_i), .start(start), .abort(abort),
    .win_len(win_len), .ack(ack), .busy(busy4), .valid(valid4),
    .count(count4), .ovf(ovf4)
  );

  int n_pass  = 0;
  int n_total = 0;

  // cmp_i waveform generator: 0 static, 1 periodic square, 2 random
  bit hist[$];
  int gcyc     = 0;
  int g_mode   = 0;
  bit g_level  = 1'b0;
  int g_period = 10;
  int g_phase  = 0;

  // Results the bench expects the DUTs to be holding
  int last_c8 = 0, last_c4 = 0;
  bit last_o8 = 1'b0, last_o4 = 1'b0;

  // Called at a negedge: drive cmp_i, record its value at the posedge,
  // return at the following negedge.
  task automatic tick();
    case (g_mode)
      0:       cmp_i = g_level;
      1:       cmp_i = (((gcyc + g_phase) % g_period) < (g_period / 2));
      default: cmp_i = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    hist.push_back(cmp_i);
    gcyc++;
    @(negedge clk);
  endtask

  task automatic measure(input string name, input int wlen, input int restart_at,
                         input int early_ack_at, input int abort_at,
                         input bit ack_with_start, input int hold);
    int weff, e0, n, rises, vhi, exp_c8, exp_c4;
    bit exp_o8, exp_o4;
    weff = (wlen == 0) ? 1 : wlen;
    start = 1'b1; win_len = WW'(wlen);
    tick();
    start = 1'b0; win_len = WW'($urandom);
    e0 = hist.size() - 1;
    n_total++;
    if (busy8 !== 1'b1 || busy4 !== 1'b1)
      $display("FAIL %s busy_after_start: busy8=%b busy4=%b required 1", name, busy8, busy4);
    else n_pass++;

    n = 0;
    while (valid8 !== 1'b1 && n < SYNC + weff + 20) begin
      if (n == restart_at)   start = 1'b1;
      if (n == early_ack_at) ack   = 1'b1;
      if (n == abort_at)     abort = 1'b1;
      tick();
      n++;
      start = 1'b0; ack = 1'b0; abort = 1'b0;
      if (abort_at >= 0 && n == abort_at + 1) begin
        n_total++;
        if (busy8 !== 1'b0 || valid8 !== 1'b0 || busy4 !== 1'b0 || valid4 !== 1'b0)
          $display("FAIL %s abort_idle: busy=%b/%b valid=%b/%b required 0", name, busy8, busy4, valid8, valid4);
        else n_pass++;
        n_total++;
        if (int'(count8) !== last_c8 || ovf8 !== last_o8 || int'(count4) !== last_c4 || ovf4 !== last_o4)
          $display("FAIL %s abort_retain: count8=%0d ovf8=%b count4=%0d ovf4=%b required %0d %b %0d %b",
                   name, count8, ovf8, count4, ovf4, last_c8, last_o8, last_c4, last_o4);
        else n_pass++;
        vhi = 0;
        repeat (SYNC + weff + 10) begin
          tick();
          if (valid8 === 1'b1 || valid4 === 1'b1 || busy8 === 1'b1) vhi++;
        end
        n_total++;
        if (vhi !== 0) $display("FAIL %s abort_stays_idle: active_cycles=%0d required 0", name, vhi);
        else n_pass++;
        return;
      end
    end

    // valid is first high in cycle SYNC+weff+1, counting the start cycle as 0
    n_total++;
    if (n !== SYNC + weff)
      $display("FAIL %s latency: valid in cycle %0d required %0d", name, n + 1, SYNC + weff + 1);
    else n_pass++;

    rises = 0;
    for (int j = 1; j <= weff && e0 + j < hist.size(); j++)
      if (hist[e0 + j] && !hist[e0 + j - 1]) rises++;
    exp_c8 = (rises > 255) ? 255 : rises;  exp_o8 = (rises > 255);
    exp_c4 = (rises > 15)  ? 15  : rises;  exp_o4 = (rises > 15);
    last_c8 = exp_c8; last_o8 = exp_o8; last_c4 = exp_c4; last_o4 = exp_o4;

    n_total++;
    if (valid4 !== 1'b1 || busy8 !== 1'b0 || busy4 !== 1'b0)
      $display("FAIL %s done_flags: valid4=%b busy=%b/%b required 1 0 0", name, valid4, busy8, busy4);
    else n_pass++;
    n_total++;
    if (int'(count8) !== exp_c8 || ovf8 !== exp_o8)
      $display("FAIL %s result_cw8: count=%0d ovf=%b required %0d %b", name, count8, ovf8, exp_c8, exp_o8);
    else n_pass++;
    n_total++;
    if (int'(count4) !== exp_c4 || ovf4 !== exp_o4)
      $display("FAIL %s result_cw4: count=%0d ovf=%b required %0d %b", name, count4, ovf4, exp_c4, exp_o4);
    else n_pass++;

    repeat (hold) begin
      tick();
      n_total++;
      if (valid8 !== 1'b1 || valid4 !== 1'b1 || int'(count8) !== exp_c8 || int'(count4) !== exp_c4)
        $display("FAIL %s hold: valid=%b/%b count=%0d/%0d required 1/1 %0d/%0d",
                 name, valid8, valid4, count8, count4, exp_c8, exp_c4);
      else n_pass++;
    end

    ack = 1'b1; start = ack_with_start;
    tick();
    ack = 1'b0; start = 1'b0;
    n_total++;
    if (valid8 !== 1'b0 || valid4 !== 1'b0 || busy8 !== 1'b0 || busy4 !== 1'b0)
      $display("FAIL %s after_ack: valid=%b/%b busy=%b/%b required 0", name, valid8, valid4, busy8, busy4);
    else n_pass++;
    if (ack_with_start) begin
      tick();
      n_total++;
      if (busy8 !== 1'b0 || busy4 !== 1'b0)
        $display("FAIL %s start_ignored: busy=%b/%b required 0", name, busy8, busy4);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0; win_len = '0;
    g_mode = 0; g_level = 1'b0; cmp_i = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    n_total++;
    if (busy8 !== 1'b0 || valid8 !== 1'b0 || count8 !== 8'd0 || ovf8 !== 1'b0)
      $display("FAIL reset_cw8: busy=%b valid=%b count=%0d ovf=%b required 0", busy8, valid8, count8, ovf8);
    else n_pass++;
    n_total++;
    if (busy4 !== 1'b0 || valid4 !== 1'b0 || count4 !== 4'd0 || ovf4 !== 1'b0)
      $display("FAIL reset_cw4: busy=%b valid=%b count=%0d ovf=%b required 0", busy4, valid4, count4, ovf4);
    else n_pass++;
    reset = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    g_mode = 1; g_period = 10; g_phase = $urandom_range(0, 9);
    measure("basic", 100, -1, -1, -1, 1'b0, 3);
    n_total++;
    if (count8 !== 8'd10 || ovf8 !== 1'b0)
      $display("FAIL basic_literal: count=%0d ovf=%b required 10 0", count8, ovf8);
    else n_pass++;
  endtask

  task automatic test_saturation();
    g_mode = 1; g_period = 2; g_phase = 0;
    measure("saturate", 64, -1, -1, -1, 1'b0, 1);
    n_total++;
    if (count4 !== 4'd15 || ovf4 !== 1'b1)
      $display("FAIL saturate_literal: count=%0d ovf=%b required 15 1", count4, ovf4);
    else n_pass++;
    g_mode = 0; g_level = 1'b0;
    measure("after_saturate", 30, -1, -1, -1, 1'b0, 0);
    n_total++;
    if (count4 !== 4'd0 || ovf4 !== 1'b0)
      $display("FAIL after_saturate_literal: count=%0d ovf=%b required 0 0", count4, ovf4);
    else n_pass++;
  endtask

  task automatic test_zero_window();
    g_mode = 0; g_level = 1'b1;
    repeat (5) tick();
    measure("zero_window", 0, -1, -1, -1, 1'b0, 0);
  endtask

  task automatic test_arm_discard();
    g_mode = 0; g_level = 1'b0;
    repeat (5) tick();
    g_level = 1'b1;  // rises with start; reaches the edge detector during ARM
    measure("arm_discard", 20, -1, -1, -1, 1'b0, 0);
    n_total++;
    if (count8 !== 8'd0) $display("FAIL arm_discard_literal: count=%0d required 0", count8);
    else n_pass++;
  endtask

  task automatic test_handshake();
    g_mode = 2;
    measure("restart_in_count", 30, 10, 3, -1, 1'b0, 2);
    measure("abort_in_count", 40, -1, -1, SYNC + 4, 1'b0, 0);
    measure("start_with_ack", 15, -1, -1, -1, 1'b1, 1);
    // abort and start together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; win_len = 16'd5;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    n_total++;
    if (busy8 !== 1'b0 || valid8 !== 1'b0)
      $display("FAIL abort_start_idle: busy=%b valid=%b required 0 0", busy8, valid8);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    g_mode = 2;
    start = 1'b1; win_len = 16'd40;
    tick();
    start = 1'b0;
    repeat (SYNC + 6) tick();
    n_total++;
    if (busy8 !== 1'b1) $display("FAIL pre_reset_busy: busy=%b required 1", busy8);
    else n_pass++;
    #10 reset = 1'b1;
    #1;
    n_total++;
    if (busy8 !== 1'b0 || valid8 !== 1'b0 || count8 !== 8'd0 || ovf8 !== 1'b0 ||
        busy4 !== 1'b0 || valid4 !== 1'b0 || count4 !== 4'd0 || ovf4 !== 1'b0)
      $display("FAIL async_reset: busy=%b/%b valid=%b/%b count=%0d/%0d ovf=%b/%b required 0",
               busy8, busy4, valid8, valid4, count8, count4, ovf8, ovf4);
    else n_pass++;
    last_c8 = 0; last_o8 = 1'b0; last_c4 = 0; last_o4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    measure("post_reset", 25, -1, -1, -1, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 0) g_mode = 2;
      else begin
        g_mode = 1; g_period = $urandom_range(2, 7); g_phase = $urandom_range(0, 6);
      end
      measure("random", $urandom_range(0, 60), -1, $urandom_range(0, 2), -1,
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_zero_window();
    test_arm_discard();
    test_handshake();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
